// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multicycle MIPS controller: opcodes, select codes,
// state encodings and the control-word layout.
package multicycle_control_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_SUB = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [1:0] SRCB_B      = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_JUMP   = 4'd9,
    S_ADDIEX = 4'd10,
    S_ADDIWB = 4'd11
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       memto_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctl_t;

  function automatic logic legal_opcode(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/mc_next_state.sv
// Combinational next-state function of the multicycle controller.
module mc_next_state
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  state_t     state,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output state_t     next
);

  logic ready;
  assign ready = MEM_HANDSHAKE ? mem_ready : 1'b1;

  always_comb begin
    next = S_FETCH;
    case (state)
      S_FETCH:  next = ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_RTYPE:     next = S_EXEC;
          OP_BEQ:       next = S_BRANCH;
          OP_ADDI:      next = S_ADDIEX;
          OP_J:         next = S_JUMP;
          default:      next = S_FETCH;
        endcase
      end
      S_MEMADR: begin
        if (opcode == OP_LW)      next = S_MEMRD;
        else if (opcode == OP_SW) next = S_MEMWR;
        else                      next = S_FETCH;
      end
      S_MEMRD:  next = ready ? S_MEMWB : S_MEMRD;
      S_MEMWR:  next = ready ? S_FETCH : S_MEMWR;
      S_EXEC:   next = S_ALUWB;
      S_ADDIEX: next = S_ADDIWB;
      default:  next = S_FETCH;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Moore controller for the multicycle MIPS datapath: state register, retired
// instruction counter and per-state control decode.
module multicycle_control
  import multicycle_control_pkg::*;
#(
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int INSTRET_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [5:0]           Opcode,
  input  logic                 Zero,
  input  logic                 MemReady,
  output logic                 PCWrite,
  output logic                 PCWriteCond,
  output logic                 PCEn,
  output logic                 IorD,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic                 MemtoReg,
  output logic                 RegDst,
  output logic                 RegWrite,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ALUOp,
  output logic [1:0]           PCSource,
  output logic                 Illegal,
  output logic [3:0]           State,
  output logic [INSTRET_W-1:0] InstRet
);

  // Memory handshake: a FETCH/MEMRD/MEMWR access is held (strobes steady)
  // until MemReady is high in the same cycle; that edge completes the access.
  state_t state;
  state_t next;
  logic   hold;
  logic   ready;
  logic   retire;
  ctl_t   ctl;

  assign ready = MEM_HANDSHAKE ? MemReady : 1'b1;

  mc_next_state #(.MEM_HANDSHAKE(MEM_HANDSHAKE)) u_next (
    .state     (state),
    .opcode    (Opcode),
    .mem_ready (MemReady),
    .next      (next)
  );

  // hold keeps outputs quiet and the FSM parked for the first cycle after
  // reset deasserts, so no write strobe can fire on a half-settled datapath.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_FETCH;
      hold    <= 1'b1;
      InstRet <= '0;
    end else begin
      hold <= 1'b0;
      if (!hold) begin
        state <= next;
        if (retire) InstRet <= InstRet + {{(INSTRET_W-1){1'b0}}, 1'b1};
      end
    end
  end

  always_comb begin
    case (state)
      S_MEMWB, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: retire = 1'b1;
      S_MEMWR: retire = ready;
      default: retire = 1'b0;
    endcase
  end

  always_comb begin
    ctl = '0;
    case (state)
      S_FETCH: begin
        ctl.mem_read  = 1'b1;
        ctl.alu_src_b = SRCB_FOUR;
        ctl.alu_op    = ALUOP_ADD;
        ctl.pc_source = PCSRC_ALU;
        ctl.ir_write  = ready;
        ctl.pc_write  = ready;
      end
      S_DECODE: begin
        ctl.alu_src_b = SRCB_IMM_SH;
        ctl.alu_op    = ALUOP_ADD;
        ctl.illegal   = !legal_opcode(Opcode);
      end
      S_MEMADR, S_ADDIEX: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_IMM;
        ctl.alu_op    = ALUOP_ADD;
      end
      S_MEMRD: begin
        ctl.mem_read = 1'b1;
        ctl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctl.reg_write = 1'b1;
        ctl.memto_reg = 1'b1;
      end
      S_MEMWR: begin
        ctl.mem_write = 1'b1;
        ctl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctl.alu_src_a = 1'b1;
        ctl.alu_src_b = SRCB_B;
        ctl.alu_op    = ALUOP_R;
      end
      S_ALUWB: begin
        ctl.reg_write = 1'b1;
        ctl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctl.alu_src_a     = 1'b1;
        ctl.alu_src_b     = SRCB_B;
        ctl.alu_op        = ALUOP_SUB;
        ctl.pc_write_cond = 1'b1;
        ctl.pc_source     = PCSRC_ALUOUT;
      end
      S_JUMP: begin
        ctl.pc_write  = 1'b1;
        ctl.pc_source = PCSRC_JUMP;
      end
      S_ADDIWB: ctl.reg_write = 1'b1;
      default: ;
    endcase
    if (reset || hold) ctl = '0;
  end

  assign PCWrite     = ctl.pc_write;
  assign PCWriteCond = ctl.pc_write_cond;
  assign PCEn        = ctl.pc_write | (ctl.pc_write_cond & Zero);
  assign IorD        = ctl.iord;
  assign MemRead     = ctl.mem_read;
  assign MemWrite    = ctl.mem_write;
  assign IRWrite     = ctl.ir_write;
  assign MemtoReg    = ctl.memto_reg;
  assign RegDst      = ctl.reg_dst;
  assign RegWrite    = ctl.reg_write;
  assign ALUSrcA     = ctl.alu_src_a;
  assign ALUSrcB     = ctl.alu_src_b;
  assign ALUOp       = ctl.alu_op;
  assign PCSource    = ctl.pc_source;
  assign Illegal     = ctl.illegal;
  assign State       = state;

endmodule
